// File: rtl/pong_pkg.sv
// Shared match-state types and widths for the pong score path.
// Screen geometry macros default here when no project config has defined them.
`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef SCREEN_H_RES
`define SCREEN_H_RES 640
`endif

package pong_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE     = 2'd1,
        PLAY      = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    // Wide enough for any serve pause up to 255 frames.
    localparam int SERVE_CNT_W = 8;

endpackage

// File: rtl/score_keeper_goal_detect.sv
// Goal detector: compares the sampled ball X against the field edges and
// gates each exit through an armed flag so a lingering ball scores only once.
module goal_detect
    import pong_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sample_i,
    input  logic [`X_POS_W-1:0] ball_x_i,
    output logic                pc_goal_o,
    output logic                player_goal_o
);

    localparam logic [`X_POS_W-1:0] RIGHT_EDGE = `X_POS_W'(`SCREEN_H_RES);
    localparam logic [`X_POS_W-1:0] LEFT_EDGE  = {`X_POS_W{1'b0}};

    logic armed_r;
    logic right_out_s;
    logic left_out_s;

    // Edge compares and goal strobes; right exit wins if both ever fire.
    always_comb begin
        right_out_s   = (ball_x_i > RIGHT_EDGE);
        left_out_s    = (ball_x_i == LEFT_EDGE);
        pc_goal_o     = sample_i & armed_r & right_out_s;
        player_goal_o = sample_i & armed_r & ~right_out_s & left_out_s;
    end

    // Armed flag: cleared by any out-of-field sample, restored by an in-field sample.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            armed_r <= 1'b1;
        end else if (sample_i) begin
            armed_r <= ~(right_out_s | left_out_s);
        end else begin
            armed_r <= armed_r;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Score keeper: goal counting, saturating scores and the match state machine.
// Define SCORE_WIN_BY_TWO_EN to require a two-point margin (saturation always wins).
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_W      = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                new_frame_i,
    input  logic [`X_POS_W-1:0] ball_x_i,
    input  logic                start_i,
    output logic [SCORE_W-1:0]  player_score_o,
    output logic [SCORE_W-1:0]  pc_score_o,
    output logic [1:0]          state_o,
    output logic                freeze_o,
    output logic                winner_o,
    output logic                goal_o
);

    localparam logic [SCORE_W-1:0]     SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0]     SCORE_ZERO = {SCORE_W{1'b0}};
    localparam logic [SCORE_W-1:0]     SCORE_ONE  = SCORE_W'(1);
    localparam logic [SCORE_W-1:0]     WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [SERVE_CNT_W-1:0] CNT_ZERO   = {SERVE_CNT_W{1'b0}};
    localparam logic [SERVE_CNT_W-1:0] CNT_ONE    = SERVE_CNT_W'(1);
    localparam logic [SERVE_CNT_W-1:0] CNT_LAST   = SERVE_CNT_W'(SERVE_FRAMES - 1);
`ifdef SCORE_WIN_BY_TWO_EN
    localparam logic [SCORE_W:0]       MARGIN     = (SCORE_W + 1)'(2);
`endif

    game_state_t             state_r;
    game_state_t             state_nxt_s;
    logic [SCORE_W-1:0]      player_score_r;
    logic [SCORE_W-1:0]      pc_score_r;
    logic [SCORE_W-1:0]      player_nxt_s;
    logic [SCORE_W-1:0]      pc_nxt_s;
    logic [SCORE_W-1:0]      player_inc_s;
    logic [SCORE_W-1:0]      pc_inc_s;
    logic [SERVE_CNT_W-1:0]  serve_cnt_r;
    logic [SERVE_CNT_W-1:0]  cnt_nxt_s;
    logic                    freeze_r;
    logic                    winner_r;
    logic                    winner_nxt_s;
    logic                    goal_r;
    logic                    goal_nxt_s;
    logic                    start_prev_r;
    logic                    sample_s;
    logic                    pc_goal_s;
    logic                    player_goal_s;
    logic                    pc_win_s;
    logic                    player_win_s;

    assign sample_s = new_frame_i & (state_r == PLAY);

    goal_detect u_goal_detect (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .sample_i      (sample_s),
        .ball_x_i      (ball_x_i),
        .pc_goal_o     (pc_goal_s),
        .player_goal_o (player_goal_s)
    );

    // Saturating post-goal scores and the win test applied to them.
    always_comb begin
        pc_inc_s     = (pc_score_r == SCORE_MAX) ? pc_score_r : pc_score_r + SCORE_ONE;
        player_inc_s = (player_score_r == SCORE_MAX) ? player_score_r : player_score_r + SCORE_ONE;
`ifdef SCORE_WIN_BY_TWO_EN
        pc_win_s     = (pc_inc_s == SCORE_MAX) ||
                       ((pc_inc_s >= WIN_VAL) && ({1'b0, pc_inc_s} >= ({1'b0, player_score_r} + MARGIN)));
        player_win_s = (player_inc_s == SCORE_MAX) ||
                       ((player_inc_s >= WIN_VAL) && ({1'b0, player_inc_s} >= ({1'b0, pc_score_r} + MARGIN)));
`else
        pc_win_s     = (pc_inc_s == WIN_VAL);
        player_win_s = (player_inc_s == WIN_VAL);
`endif
    end

    // Match FSM next-state, serve counter and score updates.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = serve_cnt_r;
        player_nxt_s = player_score_r;
        pc_nxt_s     = pc_score_r;
        winner_nxt_s = winner_r;
        goal_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_nxt_s  = SERVE;
                    cnt_nxt_s    = CNT_ZERO;
                    player_nxt_s = SCORE_ZERO;
                    pc_nxt_s     = SCORE_ZERO;
                    winner_nxt_s = 1'b0;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            SERVE: begin
                if (new_frame_i) begin
                    if (serve_cnt_r == CNT_LAST) begin
                        state_nxt_s = PLAY;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s   = serve_cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = serve_cnt_r;
                end
            end
            PLAY: begin
                if (pc_goal_s) begin
                    goal_nxt_s = 1'b1;
                    pc_nxt_s   = pc_inc_s;
                    if (pc_win_s) begin
                        state_nxt_s  = GAME_OVER;
                        winner_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s  = SERVE;
                        cnt_nxt_s    = CNT_ZERO;
                    end
                end else if (player_goal_s) begin
                    goal_nxt_s   = 1'b1;
                    player_nxt_s = player_inc_s;
                    if (player_win_s) begin
                        state_nxt_s  = GAME_OVER;
                        winner_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s  = SERVE;
                        cnt_nxt_s    = CNT_ZERO;
                    end
                end else begin
                    state_nxt_s = PLAY;
                end
            end
            GAME_OVER: begin
                // Only a fresh press leaves the result screen.
                if (start_i && !start_prev_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GAME_OVER;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, score and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r        <= IDLE;
            player_score_r <= SCORE_ZERO;
            pc_score_r     <= SCORE_ZERO;
            serve_cnt_r    <= CNT_ZERO;
            freeze_r       <= 1'b1;
            winner_r       <= 1'b0;
            goal_r         <= 1'b0;
            start_prev_r   <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            player_score_r <= player_nxt_s;
            pc_score_r     <= pc_nxt_s;
            serve_cnt_r    <= cnt_nxt_s;
            freeze_r       <= (state_nxt_s != PLAY);
            winner_r       <= winner_nxt_s;
            goal_r         <= goal_nxt_s;
            start_prev_r   <= start_i;
        end
    end

    assign player_score_o = player_score_r;
    assign pc_score_o     = pc_score_r;
    assign state_o        = state_r;
    assign freeze_o       = freeze_r;
    assign winner_o       = winner_r;
    assign goal_o         = goal_r;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed match scenarios plus random
// play, every cycle compared against a rule-level match model.
`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef SCREEN_H_RES
`define SCREEN_H_RES 640
`endif

module tb_score_keeper;

    localparam int WIN  = 11;
    localparam int SF   = 60;
    localparam int SW   = 5;
    localparam int SMAX = (1 << SW) - 1;
    localparam int H    = `SCREEN_H_RES;
    localparam int XMAX = (1 << `X_POS_W) - 1;
    localparam int MID  = 320;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                nf;
    logic                st;
    logic [`X_POS_W-1:0] bx;
    logic [SW-1:0]       player_score;
    logic [SW-1:0]       pc_score;
    logic [1:0]          state;
    logic                freeze;
    logic                winner;
    logic                goal;

    always #5 clk = ~clk;

    score_keeper #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .SCORE_W(SW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .new_frame_i    (nf),
        .ball_x_i       (bx),
        .start_i        (st),
        .player_score_o (player_score),
        .pc_score_o     (pc_score),
        .state_o        (state),
        .freeze_o       (freeze),
        .winner_o       (winner),
        .goal_o         (goal)
    );

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 serve, 2 play, 3 game over.
    int m_state, m_pc, m_pl, m_cnt;
    bit m_armed, m_prev, m_win, m_goal;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit wins(input int mine, input int other);
`ifdef SCORE_WIN_BY_TWO_EN
        return (mine == SMAX) || (mine >= WIN && mine >= other + 2);
`else
        return (mine == WIN) && (other < WIN);
`endif
    endfunction

    task automatic model_step();
        bit r, l;
        if (!rst_n) begin
            m_state = 0; m_pc = 0; m_pl = 0; m_cnt = 0;
            m_armed = 1; m_prev = 0; m_win = 0; m_goal = 0;
            return;
        end
        m_goal = 0;
        case (m_state)
            0: if (st) begin
                m_pc = 0; m_pl = 0; m_cnt = 0; m_win = 0; m_state = 1;
            end
            1: if (nf) begin
                if (m_cnt == SF - 1) begin m_state = 2; m_cnt = 0; end
                else m_cnt++;
            end
            2: if (nf) begin
                r = (int'(bx) > H);
                l = (int'(bx) < 1);
                if (r || l) begin
                    if (m_armed) begin
                        m_goal = 1;
                        if (r) begin
                            if (m_pc < SMAX) m_pc++;
                            if (wins(m_pc, m_pl)) begin m_state = 3; m_win = 1; end
                            else begin m_state = 1; m_cnt = 0; end
                        end else begin
                            if (m_pl < SMAX) m_pl++;
                            if (wins(m_pl, m_pc)) begin m_state = 3; m_win = 0; end
                            else begin m_state = 1; m_cnt = 0; end
                        end
                    end
                    m_armed = 0;
                end else begin
                    m_armed = 1;
                end
            end
            3: if (st && !m_prev) m_state = 0;
            default: m_state = 0;
        endcase
        m_prev = st;
    endtask

    // One clock with the given inputs, then compare every output to the model.
    task automatic step(input bit nf_v, input int x, input bit st_v, input bit rn_v);
        nf = nf_v; bx = x[`X_POS_W-1:0]; st = st_v; rst_n = rn_v;
        model_step();
        @(posedge clk);
        #2;
        check("state", state, m_state);
        check("pc_score", pc_score, m_pc);
        check("player_score", player_score, m_pl);
        check("freeze", freeze, (m_state != 2) ? 1 : 0);
        check("winner", winner, m_win);
        check("goal", goal, m_goal);
    endtask

    task automatic serve(input int x);
        for (int i = 0; i < SF; i++) begin
            step(1'b1, x, 1'b0, 1'b1);
            step(1'b0, x, 1'b0, 1'b1);
        end
    endtask

    task automatic goal_by(input bit pc_side, input bit st_v);
        step(1'b1, MID, 1'b0, 1'b1);
        step(1'b1, pc_side ? H + 5 : 0, st_v, 1'b1);
    endtask

    task automatic point(input bit pc_side);
        goal_by(pc_side, 1'b0);
        serve(MID);
    endtask

    task automatic new_match();
        step(1'b0, MID, 1'b1, 1'b1);
        step(1'b0, MID, 1'b0, 1'b1);
        serve(MID);
    endtask

    initial begin
        int gc;
        int r;
        bit st_rand;
        nf = 1'b0; bx = '0; st = 1'b0; rst_n = 1'b0;

        step(1'b0, MID, 1'b0, 1'b0);
        step(1'b0, MID, 1'b0, 1'b0);
        check("rst_state", state, 0);
        check("rst_scores", {pc_score, player_score}, 0);
        check("rst_freeze", freeze, 1);
        check("rst_goal", goal, 0);

        // Exits while idle are ignored.
        step(1'b1, H + 5, 1'b0, 1'b1);
        step(1'b1, 0, 1'b0, 1'b1);
        check("idle_no_goal", goal, 0);
        check("idle_no_score", {pc_score, player_score}, 0);

        step(1'b0, MID, 1'b1, 1'b1);
        check("start_serve", state, 1);
        check("start_freeze", freeze, 1);
        step(1'b0, MID, 1'b0, 1'b1);
        for (int i = 0; i < SF - 1; i++) begin
            step(1'b1, MID, 1'b0, 1'b1);
            step(1'b0, MID, 1'b0, 1'b1);
        end
        check("serve_59", state, 1);
        step(1'b1, MID, 1'b0, 1'b1);
        check("serve_done", state, 2);
        check("play_freeze", freeze, 0);

        // Ball out right for four frames: one goal only.
        gc = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, H + 5, 1'b0, 1'b1); gc += int'(goal);
            step(1'b0, H + 5, 1'b0, 1'b1); gc += int'(goal);
        end
        check("one_goal", gc, 1);
        check("pc_first", pc_score, 1);
        check("after_goal", state, 1);

        // Ball kept out through the serve pause: no score, flag stays disarmed.
        serve(H + 5);
        check("serve_out_pc", pc_score, 1);
        check("serve_out_state", state, 2);
        step(1'b1, H + 5, 1'b0, 1'b1);
        check("disarmed_goal", goal, 0);
        goal_by(1'b0, 1'b0);
        check("player_first", player_score, 1);
        check("player_goal", goal, 1);
        serve(MID);

        for (int i = 0; i < 9; i++) point(1'b1);
        for (int i = 0; i < 2; i++) point(1'b0);
        check("pc_10", pc_score, 10);
        check("pl_3", player_score, 3);
        goal_by(1'b1, 1'b1);
        check("pc_win_state", state, 3);
        check("pc_win_flag", winner, 1);
        check("pc_win_score", pc_score, 11);
        for (int i = 0; i < 5; i++) step(1'b0, MID, 1'b1, 1'b1);
        check("held_start", state, 3);
        step(1'b0, MID, 1'b0, 1'b1);
        check("released", state, 3);
        step(1'b0, MID, 1'b1, 1'b1);
        check("press_idle", state, 0);
        step(1'b0, MID, 1'b1, 1'b1);
        check("idle_to_serve", state, 1);
        step(1'b0, MID, 1'b0, 1'b1);
        serve(MID);
        check("match2_scores", {pc_score, player_score}, 0);

        for (int i = 0; i < 10; i++) begin
            point(1'b0);
            point(1'b1);
        end
        check("tie_10", {pc_score, player_score}, {5'd10, 5'd10});
        goal_by(1'b0, 1'b0);
        check("pl_11", player_score, 11);
`ifdef SCORE_WIN_BY_TWO_EN
        check("deuce_serve", state, 1);
        serve(MID);
        goal_by(1'b0, 1'b0);
        check("pl_12", player_score, 12);
`endif
        check("pl_win_state", state, 3);
        check("pl_win_flag", winner, 0);

        step(1'b0, MID, 1'b0, 1'b1);
        step(1'b0, MID, 1'b1, 1'b1);
        step(1'b0, MID, 1'b0, 1'b1);
        new_match();
        for (int i = 0; i < 5; i++) begin
            point(1'b1);
            point(1'b0);
        end
        point(1'b1);
        point(1'b1);
        check("mid_7_5", {pc_score, player_score}, {5'd7, 5'd5});
        step(1'b1, MID, 1'b0, 1'b1);
        step(1'b1, H + 5, 1'b0, 1'b0);
        check("midrst_state", state, 0);
        check("midrst_scores", {pc_score, player_score}, 0);
        check("midrst_freeze", freeze, 1);
        check("midrst_goal", goal, 0);

        // Random play, including occasional resets.
        st_rand = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            int x;
            r = $urandom_range(0, 9);
            if (r < 6) x = $urandom_range(1, H);
            else if (r < 8) x = $urandom_range(H + 1, XMAX);
            else x = 0;
            if ($urandom_range(0, 15) == 0) st_rand = ~st_rand;
            step(1'($urandom_range(0, 1)), x, st_rand, ($urandom_range(0, 2999) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
